// File: rtl/regfile_pkg.sv
// Shared defaults, FSM state encoding and address-width helper for the register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int          DEF_DW       = 32;
    localparam int          DEF_DEPTH    = 32;
    localparam int          DEF_NR       = 2;
    localparam int          DEF_NW       = 1;
    localparam bit          DEF_ZERO_R0  = 1'b1;
    localparam bit          DEF_BYPASS   = 1'b1;
    localparam int unsigned DEF_INIT_VAL = 0;

    // INIT sweeps INIT_VAL through the array; RUN serves normal traffic.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A one-entry array still needs a one-bit address bus.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset init sequencer: walks init_addr over 0..DEPTH-1, then raises ready.
// Latency: ready rises DEPTH cycles after the first edge with rst low.
// Backpressure: none; the sweep advances one entry per cycle unless rst is high.
// Ports: clk, rst (sync, active-high) -> init_we/init_addr (sweep write), ready (RUN).
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic          ready
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Power-up value keeps ready a clean 0 before the first reset.
    state_e        state_q = ST_INIT;
    state_e        state_d;
    logic [AW-1:0] cnt_q = '0;
    logic [AW-1:0] cnt_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we   = 1'b0;
        init_addr = cnt_q;
        case (state_q)
            ST_INIT: begin
                // Gate with rst so a held reset neither advances nor writes.
                init_we = ~rst;
                if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = (state_q == ST_RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with init sweep, optional r0 hardwiring and write-to-read bypass.
// Latency: writes land on the next edge; reads are combinational (0 cycles).
// Backpressure: none; writes and reads are dropped/zeroed while ready is low.
// Ports: clk, rst (sync, active-high); we/waddr/wdata (NW packed write ports);
//        raddr/rdata (NR packed read ports); ready (high once init sweep is done).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int            DW       = DEF_DW,
    parameter int            DEPTH    = DEF_DEPTH,
    parameter int            NR       = DEF_NR,
    parameter int            NW       = DEF_NW,
    parameter bit            ZERO_R0  = DEF_ZERO_R0,
    parameter bit            BYPASS   = DEF_BYPASS,
    parameter logic [DW-1:0] INIT_VAL = DW'(DEF_INIT_VAL),
    localparam int           AW       = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic             ready
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          init_we;
    logic [AW-1:0] init_addr;

    regfile_init_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    // Address is backed by storage and is not the hardwired-zero entry.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !(ZERO_R0 && (a == '0));
    endfunction

    // Write path: later ports overwrite earlier ones, so port NW-1 wins a tie.
    always_comb begin : wr_path
        logic [AW-1:0] wa;
        wa    = '0;
        mem_d = mem_q;
        if (init_we) begin
            mem_d[init_addr] = INIT_VAL;
        end else if (ready) begin
            for (int k = 0; k < NW; k++) begin
                wa = waddr[k*AW +: AW];
                if (we[k] && addr_live(wa)) begin
                    mem_d[wa] = wdata[k*DW +: DW];
                end
            end
        end
    end

    // Storage is deliberately not reset; the init sweep is what clears it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read path: bypass scans ports in the same order as the write path so the
    // forwarded value matches what will actually be stored.
    always_comb begin : rd_path
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        ra    = '0;
        rd    = '0;
        rdata = '0;
        for (int j = 0; j < NR; j++) begin
            ra = raddr[j*AW +: AW];
            rd = '0;
            if (ready && addr_live(ra)) begin
                rd = mem_q[ra];
                if (BYPASS) begin
                    for (int k = 0; k < NW; k++) begin
                        if (we[k] && (waddr[k*AW +: AW] == ra)) begin
                            rd = wdata[k*DW +: DW];
                        end
                    end
                end
            end
            rdata[j*DW +: DW] = rd;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int          DW    = 32;
    localparam int          DEPTH = 32;
    localparam int          AW    = 5;
    localparam logic [31:0] IV    = 32'd10;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [1:0]    we    = '0;
    logic [9:0]    waddr = '0;
    logic [63:0]   wdata = '0;
    logic [9:0]    raddr = '0;
    logic [63:0]   rdata;
    logic [63:0]   rdata_nb;
    logic          ready;
    logic          ready_nb;

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .DW(DW), .DEPTH(DEPTH), .NR(2), .NW(2),
        .ZERO_R0(1'b1), .BYPASS(1'b1), .INIT_VAL(IV)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .ready(ready)
    );

    regfile_mp #(
        .DW(DW), .DEPTH(DEPTH), .NR(2), .NW(2),
        .ZERO_R0(1'b1), .BYPASS(1'b0), .INIT_VAL(IV)
    ) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_nb), .ready(ready_nb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int r0, input int r1);
        raddr = {AW'(r1), AW'(r0)};
        #1;
    endtask

    task automatic set_wr(input logic [1:0] en, input int a0, input logic [31:0] d0,
                          input int a1, input logic [31:0] d1);
        we    = en;
        waddr = {AW'(a1), AW'(a0)};
        wdata = {d1, d0};
    endtask

    task automatic sweep_wait(input string tag, input bit init_writes);
        for (int c = 0; c < DEPTH; c++) begin
            if (init_writes && c >= 10) set_wr(2'b11, 3, 32'h1234, 4, 32'h5678);
            else set_wr(2'b00, 0, 0, 0, 0);
            set_rd(3, 4);
            check({tag, "_ready_lo"}, {31'd0, ready}, 32'd0);
            if (c == 20) begin
                check({tag, "_init_rd0"}, rdata[31:0], 32'd0);
                check({tag, "_init_rd1"}, rdata[63:32], 32'd0);
                check({tag, "_init_nb_rd0"}, rdata_nb[31:0], 32'd0);
            end
            tick();
        end
        set_wr(2'b00, 0, 0, 0, 0);
        #1;
        check({tag, "_ready_hi"}, {31'd0, ready}, 32'd1);
        check({tag, "_ready_nb_hi"}, {31'd0, ready_nb}, 32'd1);
    endtask

    initial begin
        #1;
        check("pre_reset_ready", {31'd0, ready}, 32'd0);

        // Hold reset three edges: the sweep must not advance meanwhile.
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        sweep_wait("sweep1", 1'b1);

        // Every register reads INIT_VAL except r0; INIT-time writes to r3/r4 dropped.
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i, DEPTH - 1 - i);
            check("all_rd0", rdata[31:0], (i == 0) ? 32'd0 : IV);
            check("all_rd1", rdata[63:32], (i == DEPTH - 1) ? 32'd0 : IV);
        end

        // Same-cycle write/read of r5 on port 0.
        set_wr(2'b01, 5, 32'hDEADBEEF, 0, 0);
        set_rd(5, 5);
        check("byp_r5", rdata[31:0], 32'hDEADBEEF);
        check("nobyp_r5", rdata_nb[31:0], IV);
        tick();
        set_wr(2'b00, 0, 0, 0, 0);
        #1;
        check("after_r5", rdata[31:0], 32'hDEADBEEF);
        check("after_nb_r5", rdata_nb[31:0], 32'hDEADBEEF);

        // Both ports hit r7: port 1 wins for storage and for bypass.
        set_wr(2'b11, 7, 32'd1, 7, 32'd2);
        set_rd(7, 7);
        check("tie_byp0", rdata[31:0], 32'd2);
        check("tie_byp1", rdata[63:32], 32'd2);
        check("tie_nobyp", rdata_nb[31:0], IV);
        tick();
        set_wr(2'b00, 0, 0, 0, 0);
        #1;
        check("tie_after", rdata[31:0], 32'd2);
        check("tie_after_nb", rdata_nb[63:32], 32'd2);

        // Port 1 alone forwards to one reader; the other reader is independent.
        set_wr(2'b10, 0, 0, 9, 32'hCAFE);
        set_rd(9, 5);
        check("p1_byp", rdata[31:0], 32'hCAFE);
        check("p1_other", rdata[63:32], 32'hDEADBEEF);
        tick();

        // r0 writes are discarded and never forwarded.
        set_wr(2'b01, 0, 32'h55, 0, 0);
        set_rd(0, 0);
        check("r0_wr_rd0", rdata[31:0], 32'd0);
        check("r0_wr_rd1", rdata[63:32], 32'd0);
        tick();
        set_wr(2'b00, 0, 0, 0, 0);
        #1;
        check("r0_after0", rdata[31:0], 32'd0);
        check("r0_after1", rdata[63:32], 32'd0);
        check("r0_after_nb", rdata_nb[31:0], 32'd0);

        // Write r20, then reset in RUN and again at sweep cnt=15.
        set_wr(2'b01, 20, 32'h99, 0, 0);
        tick();
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(20, 9);
        check("r20_written", rdata[31:0], 32'h99);
        check("r9_written", rdata[63:32], 32'hCAFE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready_lo", {31'd0, ready}, 32'd0);
        check("rst_rd_zero", rdata[31:0], 32'd0);
        for (int c = 0; c < 15; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_wait("sweep2", 1'b0);
        set_rd(20, 7);
        check("r20_reinit", rdata[31:0], IV);
        check("r7_reinit", rdata[63:32], IV);
        set_rd(5, 9);
        check("r5_reinit", rdata[31:0], IV);
        check("r9_reinit_nb", rdata_nb[63:32], IV);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DW, 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, 32, number of registers; AW = clog2(DEPTH) is derived, not overridable.
REQ-003 SHALL have parameter NR, 2, number of read ports (1..4).
REQ-004 SHALL have parameter NW, 1, number of write ports (1..2).
REQ-005 SHALL have parameter ZERO_R0, 1, which hardwires entry 0 to zero when 1.
REQ-006 SHALL have parameter BYPASS, 1, which forwards same-cycle write data to reads when 1.
REQ-007 SHALL have parameter INIT_VAL, 0, the value loaded into every entry by the init sweep.
REQ-008 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-009 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-010 SHALL have port we, input, NW, per-port write enable.
REQ-011 SHALL have port waddr, input, NW*AW, packed write addresses, with port k at bits [k*AW +: AW].
REQ-012 SHALL have port wdata, input, NW*DW, packed write data.
REQ-013 SHALL have port raddr, input, NR*AW, packed read addresses.
REQ-014 SHALL have port rdata, output, NR*DW, packed read data.
REQ-015 SHALL have port ready, output, 1, which is high once the init sweep completes.

Function
REQ-016 SHALL implement a two-state FSM: INIT (ready=0) and RUN (ready=1).
REQ-017 In INIT, SHALL write INIT_VAL to entry cnt each cycle, with cnt running 0..DEPTH-1, and SHALL enter RUN on the cycle after cnt=DEPTH-1 is written.
REQ-018 ready SHALL rise exactly DEPTH cycles after the first clk edge with rst low.
REQ-019 In INIT, SHALL ignore all we and drive every rdata to 0.
REQ-020 In RUN, when we[k]=1 and waddr[k]<DEPTH, SHALL store wdata[k] at waddr[k] on the clock edge (1-cycle write latency).
REQ-021 Reads SHALL be combinational from the array (0-cycle latency).
REQ-022 When two write ports target the same address in the same cycle, port NW-1 SHALL win.
REQ-023 When BYPASS=1 in RUN and raddr[j] matches an enabled waddr[k] in the same cycle, rdata[j] SHALL equal the winning wdata (REQ-022 priority); when BYPASS=0, SHALL return the old value.
REQ-024 When ZERO_R0=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and address 0 SHALL never be a bypass source.
REQ-025 Addresses >= DEPTH (non-power-of-2 DEPTH only) SHALL drop writes and read as 0.
REQ-026 Multiple read ports SHALL be independent; equal raddr values SHALL return equal data.

Reset
REQ-027 rst=1 SHALL force state INIT, cnt=0, and ready=0 on the next edge; the array is not cleared by rst itself.
REQ-028 rst asserted mid-sweep or in RUN SHALL restart the sweep from entry 0; the sweep SHALL not advance while rst=1.
REQ-029 Before the first reset, ready SHALL be X-free 0 in simulation (initial state INIT).

Structure
REQ-030 Default parameter values and the FSM state encoding (INIT=1'b0, RUN=1'b1) SHALL live in shared package regfile_pkg.
REQ-031 The init FSM and counter SHALL be sub-module regfile_init_seq (outputs: init_we, init_addr, ready).
REQ-032 The storage array and read/bypass muxing SHALL live in regfile_mp.

Verification (DW=32, DEPTH=32, NR=2, NW=2, INIT_VAL=10)
REQ-033 Release rst at cycle 0 -> ready=0 through cycle 31, ready=1 at cycle 32, and every register reads 10 (r0 reads 0).
REQ-034 In RUN, write r5=0xDEADBEEF on port 0 while reading r5 in the same cycle -> rdata0=0xDEADBEEF with BYPASS=1, or 10 with BYPASS=0; the next cycle reads 0xDEADBEEF.
REQ-035 Port0 writes r7=1 and port1 writes r7=2 in the same cycle -> r7 reads 2 on the next cycle, and same-cycle bypass also returns 2.
REQ-036 Write r0=0x55 -> r0 reads 0 on both read ports, during the write cycle and afterwards.
REQ-037 Assert rst for 1 cycle at sweep cnt=15 after writing r20=0x99 in RUN -> sweep restarts, ready returns after 32 more cycles, and r20 reads 10.
REQ-038 Apply we=2'b11 during INIT -> the array is unchanged by the writes, and rdata=0 until ready.
